// File: rtl/mmc3_scanline_irq_if.sv
// mmc3_scanline_irq_if: CPU register bus and PPU A12 bundle feeding the MMC3 IRQ unit
interface mmc3_scanline_irq_if;
    logic        mmc3_sel;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        ppu_a12;
    modport master (output mmc3_sel, romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12);
    modport slave  (input  mmc3_sel, romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12);
endinterface

// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq: MMC3 A12-filtered scanline counter driving the open-drain cartridge IRQ
module mmc3_scanline_irq #(
    parameter int FILTER_CYCLES = 3,
    parameter bit MMC3_ALT      = 1'b0
) (
    input  logic               m2,
    input  logic               reset_n,
    mmc3_scanline_irq_if.slave bus,
    output wire                irq,
    output logic               irq_pending
);
    localparam logic [2:0] FC = 3'(FILTER_CYCLES);
    logic [7:0]  latch, counter, next_cnt;
    logic [2:0]  low_cnt;
    logic        reload, enable, pending, a12_prev;
    logic        wr, w_c000, w_c001, w_e000, w_e001, ev, do_reload, hit;
    logic [2:0]  reg_sel;
    logic [11:0] unused_addr;
    assign unused_addr = bus.cpu_addr_in[12:1];
    always_comb begin
        wr        = bus.mmc3_sel & ~bus.romsel & ~bus.cpu_rw_in;
        reg_sel   = {bus.cpu_addr_in[14:13], bus.cpu_addr_in[0]};
        w_c000    = wr & (reg_sel == 3'b100);
        w_c001    = wr & (reg_sel == 3'b101);
        w_e000    = wr & (reg_sel == 3'b110);
        w_e001    = wr & (reg_sel == 3'b111);
        ev        = bus.ppu_a12 & ~a12_prev & (low_cnt >= FC);
        do_reload = (counter == 8'd0) | reload;
        next_cnt  = do_reload ? latch : counter - 8'd1;
        hit       = (next_cnt == 8'd0) & (~MMC3_ALT | ~do_reload | (counter != 8'd0));
    end
    always_ff @(negedge m2) begin
        if (!reset_n) begin
            latch    <= 8'd0;
            counter  <= 8'd0;
            reload   <= 1'b0;
            enable   <= 1'b0;
            pending  <= 1'b0;
            low_cnt  <= 3'd0;
            a12_prev <= 1'b0;
        end else begin
            low_cnt  <= bus.ppu_a12 ? 3'd0 : (low_cnt >= FC ? low_cnt : low_cnt + 3'd1);
            a12_prev <= bus.ppu_a12;
            latch    <= w_c000 ? bus.cpu_data_in : latch;
            counter  <= w_c001 ? 8'd0 : (ev ? next_cnt : counter);
            reload   <= w_c001 ? 1'b1 : (ev ? 1'b0 : reload);
            enable   <= w_e000 ? 1'b0 : (w_e001 ? 1'b1 : enable);
            pending  <= w_e000 ? 1'b0 : ((ev & hit & enable) ? 1'b1 : pending);
        end
    end
    assign irq         = pending ? 1'b0 : 1'bz;
    assign irq_pending = pending;
endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb_mmc3_scanline_irq: directed scoreboard bench running new and alt modes side by side
module tb_mmc3_scanline_irq;
    logic m2, rst_n, msel;
    wire  irq_n, irq_a;
    logic pend_n, pend_a;
    int   n_cmp, n_bad;
    typedef struct {
        string nm;
        logic  pn;
        logic  pa;
        int    cnt;
    } exp_t;
    exp_t sb[$];
    pullup (irq_n);
    pullup (irq_a);
    mmc3_scanline_irq_if bus ();
    mmc3_scanline_irq #(.FILTER_CYCLES(3), .MMC3_ALT(1'b0)) dut_n (
        .m2(m2), .reset_n(rst_n), .bus(bus), .irq(irq_n), .irq_pending(pend_n));
    mmc3_scanline_irq #(.FILTER_CYCLES(3), .MMC3_ALT(1'b1)) dut_a (
        .m2(m2), .reset_n(rst_n), .bus(bus), .irq(irq_a), .irq_pending(pend_a));
    initial m2 = 1'b1;
    always #5 m2 = ~m2;
    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    always @(posedge m2) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp({e.nm, ".pend_new"}, int'(pend_n), int'(e.pn));
            cmp({e.nm, ".irq_new"}, int'(irq_n === 1'b1 ? 1 : 0), int'(!e.pn));
            cmp({e.nm, ".pend_alt"}, int'(pend_a), int'(e.pa));
            cmp({e.nm, ".irq_alt"}, int'(irq_a === 1'b1 ? 1 : 0), int'(!e.pa));
            cmp({e.nm, ".cnt_new"}, int'(dut_n.counter), e.cnt);
            cmp({e.nm, ".cnt_alt"}, int'(dut_a.counter), e.cnt);
        end
    end
    // w: -1 idle, 0 $C000, 1 $C001, 2 $E000, 3 $E001, 4 reset edge
    task automatic tick(input logic a12, input int w, input logic [7:0] d, input bit chk,
                        input string nm, input logic pn, input logic pa, input int cnt);
        @(posedge m2);
        #1;
        rst_n           = (w != 4);
        bus.mmc3_sel    = msel;
        bus.ppu_a12     = a12;
        bus.romsel      = (w < 0 || w == 4);
        bus.cpu_rw_in   = (w < 0 || w == 4);
        bus.cpu_addr_in = w == 0 ? 15'h4000 : w == 1 ? 15'h4001 : w == 2 ? 15'h6000 :
                          w == 3 ? 15'h6001 : 15'h0000;
        bus.cpu_data_in = d;
        @(negedge m2);
        #1;
        if (chk) sb.push_back('{nm, pn, pa, cnt});
    endtask
    task automatic wr(input logic a12, input int w, input logic [7:0] d);
        tick(a12, w, d, 1'b0, "", 1'b0, 1'b0, 0);
    endtask
    task automatic pulse(input int nl, input string nm, input logic pn, input logic pa, input int cnt);
        for (int i = 0; i < nl; i++) wr(1'b0, -1, 8'd0);
        tick(1'b1, -1, 8'd0, 1'b1, nm, pn, pa, cnt);
    endtask
    initial begin
        n_cmp = 0;
        n_bad = 0;
        msel = 1'b1;
        rst_n = 1'b0;
        bus.mmc3_sel = 1'b1;
        bus.romsel = 1'b1;
        bus.cpu_rw_in = 1'b1;
        bus.cpu_addr_in = 15'h0;
        bus.cpu_data_in = 8'h0;
        bus.ppu_a12 = 1'b0;
        tick(1'b0, 4, 8'd0, 1'b1, "reset", 1'b0, 1'b0, 0);
        tick(1'b0, 4, 8'd0, 1'b1, "reset_hold", 1'b0, 1'b0, 0);
        tick(1'b0, 0, 8'd3, 1'b1, "c000", 1'b0, 1'b0, 0);
        wr(1'b0, 3, 8'd0);
        pulse(5, "cnt_reload3", 1'b0, 1'b0, 3);
        pulse(5, "cnt2", 1'b0, 1'b0, 2);
        pulse(5, "cnt1", 1'b0, 1'b0, 1);
        pulse(5, "cnt0_irq", 1'b1, 1'b1, 0);
        tick(1'b0, 3, 8'd0, 1'b1, "e001_keeps", 1'b1, 1'b1, 0);
        tick(1'b0, 2, 8'd0, 1'b1, "ack_e000", 1'b0, 1'b0, 0);
        wr(1'b0, 3, 8'd0);
        pulse(5, "ack_reload3", 1'b0, 1'b0, 3);
        pulse(5, "ack_cnt2", 1'b0, 1'b0, 2);
        pulse(5, "ack_cnt1", 1'b0, 1'b0, 1);
        pulse(5, "ack_irq", 1'b1, 1'b1, 0);
        tick(1'b1, 2, 8'd0, 1'b1, "flt_ack", 1'b0, 1'b0, 0);
        wr(1'b1, 0, 8'd1);
        wr(1'b1, 1, 8'd0);
        wr(1'b1, 3, 8'd0);
        for (int i = 0; i < 3; i++) pulse(2, "flt_short", 1'b0, 1'b0, 0);
        pulse(3, "flt_reload1", 1'b0, 1'b0, 1);
        pulse(3, "flt_irq", 1'b1, 1'b1, 0);
        tick(1'b1, 2, 8'd0, 1'b1, "rp_ack", 1'b0, 1'b0, 0);
        wr(1'b1, 0, 8'd5);
        wr(1'b1, 3, 8'd0);
        pulse(5, "rp_load5", 1'b0, 1'b0, 5);
        pulse(5, "rp_cnt4", 1'b0, 1'b0, 4);
        pulse(5, "rp_cnt3", 1'b0, 1'b0, 3);
        pulse(5, "rp_cnt2", 1'b0, 1'b0, 2);
        for (int i = 0; i < 3; i++) wr(1'b0, -1, 8'd0);
        tick(1'b1, 1, 8'd0, 1'b1, "rp_c001_wins", 1'b0, 1'b0, 0);
        pulse(5, "rp_reload5", 1'b0, 1'b0, 5);
        wr(1'b1, 2, 8'd0);
        wr(1'b1, 0, 8'd0);
        wr(1'b1, 1, 8'd0);
        wr(1'b1, 3, 8'd0);
        pulse(5, "l0_first", 1'b1, 1'b0, 0);
        pulse(5, "l0_second", 1'b1, 1'b0, 0);
        tick(1'b1, 2, 8'd0, 1'b1, "l0_ack", 1'b0, 1'b0, 0);
        wr(1'b1, 3, 8'd0);
        pulse(5, "l0_third", 1'b1, 1'b0, 0);
        wr(1'b1, 2, 8'd0);
        wr(1'b1, 0, 8'd2);
        wr(1'b1, 1, 8'd0);
        wr(1'b1, 3, 8'd0);
        pulse(5, "rm_load2", 1'b0, 1'b0, 2);
        pulse(5, "rm_cnt1", 1'b0, 1'b0, 1);
        tick(1'b0, 4, 8'd0, 1'b1, "rm_reset", 1'b0, 1'b0, 0);
        pulse(5, "rm_after", 1'b0, 1'b0, 0);
        msel = 1'b0;
        wr(1'b0, 0, 8'd9);
        wr(1'b0, 3, 8'd0);
        msel = 1'b1;
        wr(1'b0, 3, 8'd0);
        pulse(5, "desel_latch0", 1'b1, 1'b0, 0);
        repeat (3) @(posedge m2);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
